uart_tx_arbiter: RTL and testbench

//  Shares one UART byte transmitter between NUM_REQ APB-side requesters.
//  - Round-robin grant of one requester at a time; latches its 32-bit word and strobe.
//  - Strobe gives the byte count minus 1 (0 = 1 byte ... 3 = 4 bytes).
//  - Serialises bytes LSB-first over the dv/done byte handshake, with a per-byte done timeout.
//  - Sits between the APB write decode and the UART TX core.

---
 rtl/uart_tx_arbiter_pkg.sv | 37 +++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 48 ++++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM encoding, latched word payload,
// byte selection and timeout counter sizing.
package uart_tx_arbiter_pkg;

   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned IDX_W          = 2;
   localparam int unsigned STRB_W         = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [STRB_W-1:0] strobe;
   } word_t;

   // Counter only has to reach TIMEOUT_CYC-1; a disabled timeout still gets a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

   function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] w,
                                                  input logic [IDX_W-1:0]  i);
      case (i)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin picker: first request at or after the pointer wins; the pointer
// moves past the winner whenever the caller strobes update.
module uart_tx_arbiter_rr_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               update,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   index,
   output logic               any
);

   logic [IDX_W-1:0] ptr;

   // Two passes: indices from ptr upward, then the wrapped-around low indices.
   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (!any && (j >= int'(ptr)) && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            index    = IDX_W'(j);
         end
      end
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (!any && (j < int'(ptr)) && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            index    = IDX_W'(j);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (update && any) begin
         ptr <= (int'(index) == int'(NUM_REQ) - 1) ? '0 : index + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter between NUM_REQ word requesters:
// grants round-robin, then serialises the latched word LSB-first with a per-byte timeout.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [WORD_W*NUM_REQ-1:0] req_data,
   input  logic [STRB_W*NUM_REQ-1:0] req_strobe,
   output logic [NUM_REQ-1:0]        ack,
   output logic [BYTE_W-1:0]         tx_data,
   output logic                      tx_dv,
   input  logic                      tx_done,
   output logic                      busy,
   output logic [1:0]                owner,
   output logic                      err
);

   localparam int unsigned      CNT_W    = cnt_width(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

   state_t             state, state_n;
   word_t              word_q, word_n, word_in;
   logic [IDX_W-1:0]   bidx, bidx_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [NUM_REQ-1:0] ack_n, grant;
   logic [IDX_W-1:0]   gidx;
   logic [1:0]         owner_n;
   logic [BYTE_W-1:0]  tx_data_n;
   logic               gany, upd, err_n, expire;

   uart_tx_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .update (upd),
      .grant  (grant),
      .index  (gidx),
      .any    (gany)
   );

   // Payload of the requester the arbiter is currently pointing at.
   always_comb begin
      word_in = '0;
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (IDX_W'(j) == gidx) begin
            word_in.data   = req_data[WORD_W*j +: WORD_W];
            word_in.strobe = req_strobe[STRB_W*j +: STRB_W];
         end
      end
   end

   assign expire = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

   always_comb begin
      state_n   = state;
      word_n    = word_q;
      bidx_n    = bidx;
      cnt_n     = cnt;
      ack_n     = '0;
      err_n     = 1'b0;
      owner_n   = owner;
      upd       = 1'b0;
      tx_data_n = tx_data;
      unique case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (gany) begin
               upd     = 1'b1;
               word_n  = word_in;
               owner_n = gidx;
               ack_n   = grant;
               bidx_n  = '0;
               state_n = ST_SEND;
            end
         end
         ST_SEND: begin
            // A done arriving on the expiry cycle still counts as delivered.
            if (tx_done) begin
               cnt_n = '0;
               if (bidx == word_q.strobe) begin
                  state_n = ST_IDLE;
               end else begin
                  bidx_n  = bidx + 1'b1;
                  state_n = ST_GAP;
               end
            end else if (expire) begin
               cnt_n   = '0;
               err_n   = 1'b1;
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_GAP: begin
            cnt_n   = '0;
            state_n = ST_SEND;
         end
         default: state_n = ST_IDLE;
      endcase
      if (state_n == ST_SEND) tx_data_n = byte_sel(word_n.data, bidx_n);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         word_q  <= '0;
         bidx    <= '0;
         cnt     <= '0;
         ack     <= '0;
         err     <= 1'b0;
         owner   <= '0;
         tx_data <= '0;
         tx_dv   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         word_q  <= word_n;
         bidx    <= bidx_n;
         cnt     <= cnt_n;
         ack     <= ack_n;
         err     <= err_n;
         owner   <= owner_n;
         tx_data <= tx_data_n;
         tx_dv   <= (state_n == ST_SEND);
         busy    <= (state_n != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: predicts grants and byte streams from the
// driven requests and checks them against the UART-side handshake.
module tb_uart_tx_arbiter;

   localparam int N  = 2;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [32*N-1:0] req_data;
   logic [2*N-1:0]  req_strobe;
   logic [N-1:0]    ack;
   logic [7:0]      tx_data;
   logic            tx_dv, tx_done, busy, err;
   logic [1:0]      owner;

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .req_strobe (req_strobe),
      .ack        (ack),
      .tx_data    (tx_data),
      .tx_dv      (tx_dv),
      .tx_done    (tx_done),
      .busy       (busy),
      .owner      (owner),
      .err        (err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard entries are {owner, byte}.
   logic [9:0]  exp_q[$];
   int          grant_log[$];
   int          words_left[N];
   logic [31:0] word_data[N];
   logic [1:0]  word_strobe[N];
   int          mptr, rem, post_done, done_delay, run, last_run;
   int          gap_cnt, err_cnt, ack_cnt, popped;
   bit          spur_mode, prev_busy;

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // Requester drivers, grant model and UART byte sink, all on the falling edge.
   initial begin : engine
      int          ew;
      logic [31:0] w;
      logic [1:0]  s;
      logic [9:0]  e;
      req = '0; req_data = '0; req_strobe = '0; tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (!rst) begin
            if (ack != '0) begin
               ack_cnt++;
               ew = rr_pick(req, mptr);
               check("ack_has_req", 64'(ew >= 0), 1);
               if (ew >= 0) begin
                  check("ack_onehot", 64'(ack), 64'(1) << ew);
                  check("ack_owner", 64'(owner), 64'(ew));
                  check("ack_after_idle", 64'(prev_busy), 0);
                  check("ack_dv", 64'(tx_dv), 1);
                  mptr = (ew + 1) % N;
                  grant_log.push_back(ew);
                  w = req_data[32*ew +: 32];
                  s = req_strobe[2*ew +: 2];
                  for (int b = 0; b <= int'(s); b++) exp_q.push_back({2'(ew), w[8*b +: 8]});
                  rem = int'(s) + 1;
                  if (words_left[ew] > 0) words_left[ew]--;
                  word_data[ew] = $urandom();
               end
            end
            if (err) begin
               err_cnt++;
               check("err_dv_low", 64'(tx_dv), 0);
            end
            if (post_done == 1) begin
               if (rem > 0) begin
                  check("gap_dv", 64'(tx_dv), 0);
                  check("gap_busy", 64'(busy), 1);
                  post_done = 2;
               end else begin
                  check("end_busy", 64'(busy), 0);
                  check("end_dv", 64'(tx_dv), 0);
                  post_done = 0;
               end
            end else if (post_done == 2) begin
               check("gap_len", 64'(tx_dv), 1);
               post_done = 0;
            end
            if (tx_dv) begin
               run++;
               if (run == done_delay) begin
                  check("byte_expected", 64'(exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     check("tx_data", 64'(tx_data), 64'(e[7:0]));
                     check("tx_owner", 64'(owner), 64'(e[9:8]));
                  end
                  popped++;
                  rem--;
                  tx_done   = 1'b1;
                  post_done = 1;
               end
            end else begin
               if (run > 0) last_run = run;
               run = 0;
               if (spur_mode) tx_done = 1'b1;
               if (busy) gap_cnt++;
            end
         end else begin
            run = 0;
         end
         prev_busy = busy;
         for (int i = 0; i < N; i++) begin
            req[i]             = (words_left[i] > 0);
            req_data[32*i +: 32] = word_data[i];
            req_strobe[2*i +: 2] = word_strobe[i];
         end
      end
   end

   // Called just after a rising edge; checks the asynchronous clear before any edge.
   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) words_left[i] = 0;
      exp_q.delete();
      mptr = 0; rem = 0; post_done = 0;
      #1;
      check("rst_dv", 64'(tx_dv), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_ack", 64'(ack), 0);
      check("rst_err", 64'(err), 0);
      check("rst_data", 64'(tx_data), 0);
      check("rst_owner", 64'(owner), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      bit ok = 0;
      repeat (3) @(posedge clk);
      while (!ok && n < budget) begin
         @(posedge clk); #1;
         n++;
         if (!busy && exp_q.size() == 0 && req == '0 &&
             words_left[0] == 0 && words_left[1] == 0) ok = 1;
      end
      check(tag, 64'(ok), 1);
   endtask

   initial begin : main
      int a0, p0, g0, e0, n;
      bit hit;
      rst = 1'b1;
      spur_mode = 0; done_delay = 5;
      mptr = 0; rem = 0; post_done = 0; run = 0; last_run = 0;
      gap_cnt = 0; err_cnt = 0; ack_cnt = 0; popped = 0; prev_busy = 0;
      for (int i = 0; i < N; i++) begin
         words_left[i] = 0; word_data[i] = '0; word_strobe[i] = '0;
      end
      @(posedge clk); #1;
      do_reset();

      // Two requesters held high: owner alternates from 0.
      @(posedge clk); #1;
      grant_log.delete();
      done_delay = 2;
      word_data[0] = 32'h0102_0304; word_data[1] = 32'hF0E0_D0C0;
      word_strobe[0] = 2'd0; word_strobe[1] = 2'd0;
      words_left[0] = 3; words_left[1] = 3;
      wait_idle("t2_idle", 300);
      check("t2_grants", 64'(grant_log.size()), 6);
      for (int i = 0; i < 6; i++)
         if (i < grant_log.size()) check("t2_owner", 64'(grant_log[i]), 64'(i % 2));

      // Four-byte word, LSB first, one gap cycle between bytes.
      a0 = ack_cnt; p0 = popped; g0 = gap_cnt;
      done_delay = 5;
      word_data[0] = 32'hA1B2_C3D4; word_strobe[0] = 2'd3; words_left[0] = 1;
      wait_idle("t1_idle", 200);
      check("t1_acks", 64'(ack_cnt - a0), 1);
      check("t1_bytes", 64'(popped - p0), 4);
      check("t1_gaps", 64'(gap_cnt - g0), 3);

      // No done at all: timeout after TO cycles of tx_dv.
      e0 = err_cnt;
      done_delay = 0;
      word_data[0] = 32'h7788_99AA; word_strobe[0] = 2'd1; words_left[0] = 1;
      n = 0;
      while (err_cnt == e0 && n < 80) begin
         @(posedge clk); #1;
         n++;
      end
      check("t3_err", 64'(err_cnt - e0), 1);
      check("t3_run", 64'(last_run), 64'(TO));
      check("t3_unsent", 64'(exp_q.size()), 2);
      exp_q.delete(); rem = 0; post_done = 0;
      repeat (3) @(posedge clk); #1;
      check("t3_idle_busy", 64'(busy), 0);
      check("t3_idle_dv", 64'(tx_dv), 0);

      // Done on the expiry cycle wins over the timeout.
      e0 = err_cnt; p0 = popped;
      done_delay = TO;
      word_data[0] = 32'h1234_5678; word_strobe[0] = 2'd1; words_left[0] = 1;
      wait_idle("t3b_idle", 200);
      check("t3b_no_err", 64'(err_cnt - e0), 0);
      check("t3b_bytes", 64'(popped - p0), 2);
      check("t3b_run", 64'(last_run), 64'(TO));

      // Spurious done in IDLE and GAP is ignored.
      spur_mode = 1;
      repeat (4) @(posedge clk); #1;
      check("t5_idle_busy", 64'(busy), 0);
      a0 = ack_cnt; p0 = popped; g0 = gap_cnt;
      done_delay = 2;
      word_data[0] = 32'hC0FF_EE11; word_strobe[0] = 2'd2; words_left[0] = 1;
      wait_idle("t5_idle", 200);
      spur_mode = 0;
      check("t5_acks", 64'(ack_cnt - a0), 1);
      check("t5_bytes", 64'(popped - p0), 3);
      check("t5_gaps", 64'(gap_cnt - g0), 2);

      // Late requester waits for IDLE and is sampled at its grant.
      grant_log.delete();
      done_delay = 4;
      word_data[0] = 32'h1122_3344; word_strobe[0] = 2'd2; words_left[0] = 1;
      n = 0; hit = 0;
      while (!hit && n < 20) begin
         @(posedge clk); #1;
         n++;
         hit = busy;
      end
      check("t6_busy", 64'(hit), 1);
      word_data[1] = 32'hDEAD_BEEF; word_strobe[1] = 2'd1; words_left[1] = 1;
      repeat (3) @(posedge clk); #1;
      word_data[1] = 32'h5A6B_7C8D;
      check("t6_owner_hold", 64'(owner), 0);
      wait_idle("t6_idle", 200);
      check("t6_grants", 64'(grant_log.size()), 2);
      if (grant_log.size() == 2) begin
         check("t6_first", 64'(grant_log[0]), 0);
         check("t6_second", 64'(grant_log[1]), 1);
      end

      // Reset during byte 2 of a 4-byte word, then restart from byte 0 with ptr 0.
      done_delay = 3; p0 = popped;
      word_data[0] = 32'hCAFE_F00D; word_strobe[0] = 2'd3; words_left[0] = 1;
      n = 0; hit = 0;
      while (!hit && n < 80) begin
         @(posedge clk); #1;
         n++;
         hit = (popped >= p0 + 2) && tx_dv;
      end
      check("t4_reached", 64'(hit), 1);
      check("t4_pre_dv", 64'(tx_dv), 1);
      do_reset();
      @(posedge clk); #1;
      grant_log.delete();
      word_data[0] = 32'h0BAD_C0DE; word_strobe[0] = 2'd3;
      word_data[1] = 32'h1357_2468; word_strobe[1] = 2'd0;
      words_left[0] = 1; words_left[1] = 1;
      wait_idle("t4_idle", 200);
      check("t4_grants", 64'(grant_log.size()), 2);
      if (grant_log.size() == 2) begin
         check("t4_first", 64'(grant_log[0]), 0);
         check("t4_second", 64'(grant_log[1]), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
